// File: rtl/spi_word_sequencer.sv
// Plays a DEPTH-entry table of 24-bit words into a SPI parallel-to-serial stage,
// one frame per word. Define SEQ_LOOP_EN to restart the sequence while start is held.
module spi_word_sequencer #(
  parameter int DEPTH   = 16,
  parameter int AW      = 4,
  parameter int GAP     = 4,
  parameter int TIMEOUT = 63
) (
  input  logic          sclk,
  input  logic          cfg_rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [23:0]   wr_data,
  input  logic          start,
  input  logic [AW:0]   num_words,
  input  logic          sync_in,
  output logic          spi_rst_n,
  output logic [23:0]   spi_data,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [AW-1:0] word_idx
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_GAP   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [2:0]    state;
  logic [23:0]   tbl [DEPTH];
  logic [AW:0]   n_lat;
  logic [CW-1:0] cyc;
  logic [GW-1:0] gcnt;
  logic          seen_low;

  logic          wr_ok;
  logic [AW:0]   n_clamp;
  logic [AW:0]   nxt_idx;
  logic [23:0]   first_word;
  logic          go;

  assign wr_ok   = wr_en && !busy && ({1'b0, wr_addr} < DEPTH_W);
  assign n_clamp = (num_words > DEPTH_W) ? DEPTH_W : num_words;
  assign nxt_idx = {1'b0, word_idx} + 1'b1;
  assign go      = start && (num_words != '0);
  // A write landing on the same edge as start must be the value that gets sent.
  assign first_word = (wr_ok && wr_addr == '0) ? wr_data : tbl[0];

  always_ff @(posedge sclk) begin
    if (cfg_rst) begin
      state     <= S_IDLE;
      spi_rst_n <= 1'b0;
      spi_data  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      word_idx  <= '0;
      n_lat     <= '0;
      cyc       <= '0;
      gcnt      <= '0;
      seen_low  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) tbl[i] <= '0;
    end else begin
      done <= 1'b0;
      if (wr_ok) tbl[wr_addr] <= wr_data;
      case (state)
        S_IDLE: begin
          spi_rst_n <= 1'b0;
          if (go) begin
            n_lat    <= n_clamp;
            word_idx <= '0;
            err      <= 1'b0;
            busy     <= 1'b1;
            spi_data <= first_word;
            state    <= S_LOAD;
          end
        end
        S_LOAD: begin
          spi_rst_n <= 1'b1;
          cyc       <= '0;
          seen_low  <= 1'b0;
          state     <= S_SHIFT;
        end
        S_SHIFT: begin
          // Dropping reset on the closing sync edge kills the serializer's next frame.
          if (sync_in && seen_low) begin
            spi_rst_n <= 1'b0;
            gcnt      <= '0;
            state     <= S_GAP;
          end else if (cyc == CW'(TIMEOUT - 1)) begin
            err       <= 1'b1;
            busy      <= 1'b0;
            spi_rst_n <= 1'b0;
            state     <= S_IDLE;
          end else begin
            cyc <= cyc + 1'b1;
            if (!sync_in) seen_low <= 1'b1;
          end
        end
        S_GAP: begin
          if (gcnt == GW'(GAP - 1)) begin
            if (nxt_idx < n_lat) begin
              word_idx <= nxt_idx[AW-1:0];
              spi_data <= tbl[nxt_idx[AW-1:0]];
              state    <= S_LOAD;
            end else begin
`ifdef SEQ_LOOP_EN
              done <= 1'b1;
              if (go) begin
                n_lat    <= n_clamp;
                word_idx <= '0;
                spi_data <= tbl[0];
                state    <= S_LOAD;
              end else begin
                busy  <= 1'b0;
                state <= S_IDLE;
              end
`else
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= S_DONE;
`endif
            end
          end else begin
            gcnt <= gcnt + 1'b1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_word_sequencer.sv
// Bench for spi_word_sequencer: a behavioural 24-bit serializer feeds a frame
// scoreboard; directed tests cover table play-out, clamping, timeout, reset and gaps.
module tb_spi_word_sequencer;
  localparam int TO = 63;

  logic        sclk = 0;
  logic        cfg_rst = 1;
  logic        wr_en = 0;
  logic [3:0]  wr_addr = 0;
  logic [23:0] wr_data = 0;
  logic        start = 0;
  logic [4:0]  num_words = 0;
  logic        sync_in;
  logic        spi_rst_n;
  logic [23:0] spi_data;
  logic        busy, done, err;
  logic [3:0]  word_idx;

  spi_word_sequencer dut (
    .sclk(sclk), .cfg_rst(cfg_rst), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .start(start), .num_words(num_words), .sync_in(sync_in),
    .spi_rst_n(spi_rst_n), .spi_data(spi_data), .busy(busy), .done(done),
    .err(err), .word_idx(word_idx)
  );

  always #5 sclk = ~sclk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", nm, act, req);
    end
  endtask

  // Serializer model: loads while reset low, then 24 bits MSB-first with sync low,
  // one cycle of sync high, and wraps to a new frame.
  logic [23:0] ser_sh  = 0;
  logic [4:0]  ser_cnt = 0;
  bit          tie_sync = 0;
  assign sync_in = tie_sync ? 1'b1 : ((spi_rst_n !== 1'b1) ? 1'b1 : (ser_cnt == 5'd24));

  always @(posedge sclk) begin
    if (spi_rst_n !== 1'b1) begin
      ser_sh <= spi_data; ser_cnt <= 0;
    end else if (ser_cnt == 5'd24) begin
      ser_sh <= spi_data; ser_cnt <= 0;
    end else begin
      ser_sh <= ser_sh << 1; ser_cnt <= ser_cnt + 1'b1;
    end
  end

  // Scoreboard: expected frames queued by stimulus, popped as bits arrive.
  logic [23:0] exp_q[$];
  logic [23:0] rx = 0;
  int          rx_n = 0;
  bit          abort_ok = 0;

  always @(posedge sclk) begin
    if (spi_rst_n !== 1'b1) begin
      if (rx_n != 0 && !abort_ok) begin
        n_tests++; n_fail++;
        $display("FAIL partial_frame: got %0d bits required 24", rx_n);
      end
      rx_n = 0;
    end else if (!tie_sync && ser_cnt < 5'd24) begin
      rx = {rx[22:0], ser_sh[23]};
      rx_n++;
      if (rx_n == 24) begin
        rx_n = 0;
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_frame: got %06h required none", rx);
        end else begin
          chk("frame", rx, exp_q.pop_front());
        end
      end
    end
  end

  int done_cnt = 0;
  int wmax = 0;
  always @(negedge sclk) begin
    if (done === 1'b1) done_cnt++;
    if (busy === 1'b1 && int'(word_idx) > wmax) wmax = int'(word_idx);
  end

  logic [23:0] mdl [16];

  task automatic tick(); @(negedge sclk); endtask

  task automatic wr(input int a, input logic [23:0] d);
    wr_en = 1; wr_addr = 4'(a); wr_data = d; tick(); wr_en = 0;
  endtask

  task automatic pulse_start(input int n);
    start = 1; num_words = 5'(n); tick(); start = 0;
  endtask

  task automatic wait_done(input string nm, input int budget);
    for (int k = 0; k < budget && done !== 1'b1; k++) tick();
    chk(nm, done, 1);
    tick();
  endtask

  task automatic count_low_gap(input string nm);
    int k, lo;
    for (k = 0; k < 100 && spi_rst_n !== 1'b0; k++) tick();
    lo = 0;
    for (k = 0; k < 50 && spi_rst_n === 1'b0; k++) begin lo++; tick(); end
    chk(nm, lo, 5);
  endtask

  initial begin
    int d0, k, hi;
    bit ok;
    repeat (3) tick();
    cfg_rst = 0;
    tick();
    chk("rst_spi_rst_n", spi_rst_n, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_word_idx", word_idx, 0);
    chk("rst_spi_data", spi_data, 0);

    // T1: two words; table[1] written in the same cycle as start
    wr(0, 24'hA5F00F);
    wr(1, 24'hFFFFFF);
    exp_q.push_back(24'hA5F00F);
    exp_q.push_back(24'h123456);
    d0 = done_cnt;
    wr_en = 1; wr_addr = 1; wr_data = 24'h123456;
    start = 1; num_words = 2;
    tick();
    wr_en = 0; start = 0;
    chk("t1_busy", busy, 1);
    wait_done("t1_done_seen", 200);
    tick();
    chk("t1_done_count", done_cnt - d0, 1);
    chk("t1_err", err, 0);
    chk("t1_busy_end", busy, 0);

    // T2: zero words ignored, then 20 clamps to 16
    d0 = done_cnt;
    pulse_start(0);
    ok = 1;
    for (k = 0; k < 10; k++) begin
      if (busy !== 1'b0 || spi_rst_n !== 1'b0) ok = 0;
      tick();
    end
    chk("t2_zero_idle", ok, 1);
    chk("t2_zero_no_done", done_cnt - d0, 0);
    for (int i = 0; i < 16; i++) begin
      mdl[i] = 24'(i * 24'h0F0F11 + 24'h00A001);
      wr(i, mdl[i]);
      exp_q.push_back(mdl[i]);
    end
    wmax = 0;
    d0 = done_cnt;
    pulse_start(20);
    wait_done("t2_done_seen", 1000);
    tick();
    chk("t2_done_count", done_cnt - d0, 1);
    chk("t2_word_idx_max", wmax, 15);
    chk("t2_frames_left", exp_q.size(), 0);

    // T3: serializer absent -> timeout
    tie_sync = 1;
    d0 = done_cnt;
    pulse_start(1);
    for (k = 0; k < 20 && spi_rst_n !== 1'b1; k++) tick();
    hi = 0;
    for (k = 0; k < 200 && spi_rst_n === 1'b1; k++) begin hi++; tick(); end
    chk("t3_shift_cycles", hi, TO);
    chk("t3_err", err, 1);
    chk("t3_busy", busy, 0);
    repeat (5) tick();
    chk("t3_err_sticky", err, 1);
    chk("t3_no_done", done_cnt - d0, 0);
    tie_sync = 0;
    exp_q.push_back(mdl[0]);
    pulse_start(1);
    chk("t3_err_cleared", err, 0);
    wait_done("t3_retry_done", 200);

    // T4: reset in the middle of word 1 of 3
    exp_q.push_back(mdl[0]);
    pulse_start(3);
    for (k = 0; k < 200 && !(word_idx == 4'd1 && spi_rst_n === 1'b1); k++) tick();
    chk("t4_reached_word1", word_idx, 1);
    repeat (5) tick();
    abort_ok = 1;
    cfg_rst = 1;
    tick();
    cfg_rst = 0;
    chk("t4_spi_rst_n", spi_rst_n, 0);
    chk("t4_busy", busy, 0);
    chk("t4_word_idx", word_idx, 0);
    chk("t4_spi_data", spi_data, 0);
    ok = 1;
    for (k = 0; k < 60; k++) begin
      if (spi_rst_n !== 1'b0 || busy !== 1'b0) ok = 0;
      tick();
    end
    chk("t4_quiet_after_rst", ok, 1);
    abort_ok = 0;
    for (int i = 0; i < 3; i++) exp_q.push_back(24'h000000);
    pulse_start(3);
    wait_done("t4_cleared_table_done", 300);

    // T5: write while busy is dropped; gap between frames is GAP+LOAD
    wr(0, 24'h111111);
    wr(1, 24'h222222);
    wr(2, 24'h333333);
    exp_q.push_back(24'h111111);
    exp_q.push_back(24'h222222);
    exp_q.push_back(24'h333333);
    pulse_start(3);
    wr(2, 24'hDEADBE);
    count_low_gap("t5_gap01");
    count_low_gap("t5_gap12");
    wait_done("t5_done_seen", 200);

`ifdef SEQ_LOOP_EN
    // T6: start held loops passes; dropping it ends after the current pass
    for (int p = 0; p < 3; p++) begin
      exp_q.push_back(24'h111111);
      exp_q.push_back(24'h222222);
    end
    d0 = done_cnt;
    start = 1; num_words = 2;
    for (k = 0; k < 200 && done !== 1'b1; k++) tick();
    chk("t6_pass1_done", done, 1);
    chk("t6_pass1_busy", busy, 1);
    tick();
    for (k = 0; k < 200 && done !== 1'b1; k++) tick();
    chk("t6_pass2_done", done, 1);
    start = 0;
    tick();
    wait_done("t6_pass3_done", 200);
    tick();
    chk("t6_done_count", done_cnt - d0, 3);
    chk("t6_busy_end", busy, 0);
`endif

    repeat (40) tick();
    chk("sb_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
